// File: rtl/mem_txn_display.sv
// mem_txn_display: formats memory transactions as digit codes for a six-digit seven-segment bank.
// Optional DISP_STICKY_EN keeps the last transaction on screen after its hold time expires.
module mem_txn_display #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txn_valid,
  output logic        txn_ready,
  input  logic        txn_write,
  input  logic [7:0]  txn_addr,
  input  logic [7:0]  txn_data,
  output logic [29:0] digit_codes,
  output logic        disp_busy
);

  localparam int unsigned      CNT_W  = $clog2(HOLD_CYCLES);
  localparam logic [29:0]      DASHES = {6{5'd20}};
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      disp_q, disp_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_write_q, pend_write_d;
  logic [7:0]       pend_addr_q, pend_addr_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             accept;

  // digit5 = r/t, digit4 blank, then addr and data as hex nibbles
  function automatic logic [29:0] fmt(input logic wr, input logic [7:0] a, input logic [7:0] d);
    return {(wr ? 5'd18 : 5'd16), 5'd31, 1'b0, a[7:4], 1'b0, a[3:0], 1'b0, d[7:4], 1'b0, d[3:0]};
  endfunction

  assign txn_ready   = !pend_valid_q;
  assign accept      = txn_valid && txn_ready;
  assign digit_codes = disp_q;
  assign disp_busy   = (state_q == StShow);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          disp_d  = fmt(txn_write, txn_addr, txn_data);
          cnt_d   = RELOAD;
          state_d = StShow;
        end
      end
      StShow: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (accept) begin
            pend_valid_d = 1'b1;
            pend_write_d = txn_write;
            pend_addr_d  = txn_addr;
            pend_data_d  = txn_data;
          end
        end else if (pend_valid_q) begin
          disp_d       = fmt(pend_write_q, pend_addr_q, pend_data_q);
          pend_valid_d = 1'b0;
          cnt_d        = RELOAD;
        end else if (accept) begin
          // bypass: the incoming transaction follows without a dash frame
          disp_d = fmt(txn_write, txn_addr, txn_data);
          cnt_d  = RELOAD;
        end else begin
          state_d = StIdle;
`ifndef DISP_STICKY_EN
          disp_d  = DASHES;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      disp_q       <= DASHES;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_mem_txn_display.sv
// Directed testbench for mem_txn_display with HOLD_CYCLES = 4.
module tb_mem_txn_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        txn_valid = 1'b0;
  logic        txn_ready;
  logic        txn_write = 1'b0;
  logic [7:0]  txn_addr = 8'h00;
  logic [7:0]  txn_data = 8'h00;
  logic [29:0] digit_codes;
  logic        disp_busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DISP_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [29:0] DASH = {6{5'd20}};
  localparam logic [29:0] RA   = {5'd16, 5'd31, 5'd3, 5'd12, 5'd10, 5'd5};   // read 3C/A5
  localparam logic [29:0] WB   = {5'd18, 5'd31, 5'd1, 5'd0, 5'd7, 5'd7};     // write 10/77
  localparam logic [29:0] RC   = {5'd16, 5'd31, 5'd5, 5'd5, 5'd6, 5'd6};     // read 55/66
  localparam logic [29:0] WX   = {5'd18, 5'd31, 5'd1, 5'd2, 5'd3, 5'd4};     // write 12/34
  localparam logic [29:0] RY   = {5'd16, 5'd31, 5'd15, 5'd15, 5'd0, 5'd0};   // read FF/00
  localparam logic [29:0] WS   = {5'd18, 5'd31, 5'd2, 5'd10, 5'd5, 5'd11};   // write 2A/5B

  mem_txn_display #(.HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .txn_valid  (txn_valid),
    .txn_ready  (txn_ready),
    .txn_write  (txn_write),
    .txn_addr   (txn_addr),
    .txn_data   (txn_data),
    .digit_codes(digit_codes),
    .disp_busy  (disp_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [7:0] a, input logic [7:0] d);
    txn_valid = 1'b1;
    txn_write = wr;
    txn_addr  = a;
    txn_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (digit_codes !== DASH) begin n_bad++; $display("FAIL reset_digits got %h want %h", digit_codes, DASH); end
    n_cmp++; if (disp_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", disp_busy); end
    n_cmp++; if (txn_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", txn_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    offer(1'b0, 8'h3C, 8'hA5);
    tick();
    txn_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (digit_codes !== RA) begin n_bad++; $display("FAIL single_shown[%0d] got %h want %h", i, digit_codes, RA); end
      n_cmp++; if (disp_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy[%0d] got %b want 1", i, disp_busy); end
      tick();
    end
    n_cmp++; if (digit_codes !== (STICKY ? RA : DASH)) begin n_bad++; $display("FAIL single_idle got %h want %h", digit_codes, STICKY ? RA : DASH); end
    n_cmp++; if (disp_busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", disp_busy); end
  endtask

  task automatic test_queue();
    offer(1'b0, 8'h3C, 8'hA5);
    tick();                                   // A accepted, cnt=3
    offer(1'b1, 8'h10, 8'h77);
    tick();                                   // B into pending, cnt=2
    n_cmp++; if (txn_ready !== 1'b0) begin n_bad++; $display("FAIL queue_ready_low got %b want 0", txn_ready); end
    offer(1'b0, 8'h55, 8'h66);                // C held off
    tick();
    tick();                                   // cnt=0
    n_cmp++; if (digit_codes !== RA) begin n_bad++; $display("FAIL queue_a_last got %h want %h", digit_codes, RA); end
    n_cmp++; if (txn_ready !== 1'b0) begin n_bad++; $display("FAIL queue_ready_expiry got %b want 0", txn_ready); end
    tick();                                   // expiry: B loaded
    n_cmp++; if (digit_codes !== WB) begin n_bad++; $display("FAIL queue_b_shown got %h want %h", digit_codes, WB); end
    n_cmp++; if (txn_ready !== 1'b1) begin n_bad++; $display("FAIL queue_ready_back got %b want 1", txn_ready); end
    tick();                                   // C accepted into pending
    txn_valid = 1'b0;
    n_cmp++; if (txn_ready !== 1'b0) begin n_bad++; $display("FAIL queue_c_accepted got %b want 0", txn_ready); end
    tick();
    tick();
    n_cmp++; if (digit_codes !== WB) begin n_bad++; $display("FAIL queue_b_last got %h want %h", digit_codes, WB); end
    tick();
    n_cmp++; if (digit_codes !== RC) begin n_bad++; $display("FAIL queue_c_shown got %h want %h", digit_codes, RC); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (digit_codes !== (STICKY ? RC : DASH)) begin n_bad++; $display("FAIL queue_idle got %h want %h", digit_codes, STICKY ? RC : DASH); end
    n_cmp++; if (disp_busy !== 1'b0) begin n_bad++; $display("FAIL queue_idle_busy got %b want 0", disp_busy); end
  endtask

  task automatic test_bypass();
    offer(1'b1, 8'h12, 8'h34);
    tick();
    txn_valid = 1'b0;
    tick();
    tick();
    tick();                                   // cnt=0, expiry next edge
    n_cmp++; if (digit_codes !== WX) begin n_bad++; $display("FAIL bypass_first got %h want %h", digit_codes, WX); end
    offer(1'b0, 8'hFF, 8'h00);
    tick();
    txn_valid = 1'b0;
    n_cmp++; if (digit_codes !== RY) begin n_bad++; $display("FAIL bypass_second got %h want %h", digit_codes, RY); end
    n_cmp++; if (disp_busy !== 1'b1) begin n_bad++; $display("FAIL bypass_busy got %b want 1", disp_busy); end
    tick();
    tick();
    tick();
    n_cmp++; if (digit_codes !== RY) begin n_bad++; $display("FAIL bypass_hold got %h want %h", digit_codes, RY); end
    tick();
    n_cmp++; if (digit_codes !== (STICKY ? RY : DASH)) begin n_bad++; $display("FAIL bypass_idle got %h want %h", digit_codes, STICKY ? RY : DASH); end
  endtask

  task automatic test_reset_mid();
    offer(1'b0, 8'h3C, 8'hA5);
    tick();
    offer(1'b1, 8'h10, 8'h77);
    tick();
    txn_valid = 1'b0;
    n_cmp++; if (txn_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pending got %b want 0", txn_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (digit_codes !== DASH) begin n_bad++; $display("FAIL mid_digits got %h want %h", digit_codes, DASH); end
    n_cmp++; if (txn_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", txn_ready); end
    n_cmp++; if (disp_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", disp_busy); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (digit_codes !== DASH) begin n_bad++; $display("FAIL mid_no_pending[%0d] got %h want %h", i, digit_codes, DASH); end
    end
  endtask

  task automatic test_sticky();
    offer(1'b1, 8'h2A, 8'h5B);
    tick();
    txn_valid = 1'b0;
    n_cmp++; if (digit_codes !== WS) begin n_bad++; $display("FAIL sticky_shown got %h want %h", digit_codes, WS); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (digit_codes !== (STICKY ? WS : DASH)) begin n_bad++; $display("FAIL sticky_after got %h want %h", digit_codes, STICKY ? WS : DASH); end
    n_cmp++; if (disp_busy !== 1'b0) begin n_bad++; $display("FAIL sticky_busy got %b want 0", disp_busy); end
    tick();
    n_cmp++; if (digit_codes !== (STICKY ? WS : DASH)) begin n_bad++; $display("FAIL sticky_stays got %h want %h", digit_codes, STICKY ? WS : DASH); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_bypass();
    test_reset_mid();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
